// File: rtl/usb_hist_uploader.sv
// USB command decoder and histogram uploader: pops command words from the
// ISP1362 read port and streams channel counts (plus checksum) to the write port.
module usb_hist_uploader #(
    parameter int          N_CH      = 1024,
    parameter int          AW        = 10,
    parameter int          CW        = 32,
    parameter int          RD_LAT    = 1,
    parameter int          EN_SUM    = 1,
    parameter logic [15:0] CMD_FETCH = 16'hFFFF,
    parameter logic [15:0] CMD_START = 16'hFFEE,
    parameter logic [15:0] CMD_PAUSE = 16'hFFDD,
    parameter logic [15:0] CMD_CLEAR = 16'hFFCC
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic          usb_read_wait,
    output logic          usb_read_en,
    input  logic [15:0]   usb_read_data,
    input  logic          usb_write_wait,
    output logic          usb_write_en,
    output logic [15:0]   usb_write_data,
    output logic [AW-1:0] channel_address,
    input  logic [CW-1:0] channel_count,
    output logic          cmd_start,
    output logic          cmd_pause,
    output logic          cmd_clear,
    output logic          busy,
    output logic [15:0]   last_cmd,
    output logic [8:0]    LEDG
);
    localparam int WPC = CW / 16;
    localparam int KW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam logic [1:0]    LAT    = 2'(RD_LAT);
    localparam logic [KW-1:0] K_LAST = KW'(WPC - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N_CH - 1);

    typedef enum logic [1:0] {R_IDLE, R_POP, R_CAP} rstate_t;
    typedef enum logic [2:0] {W_IDLE, W_WAIT, W_WORD, W_GAP, W_SUM} wstate_t;

    rstate_t rstate_reg, rstate_next;
    wstate_t wstate_reg, wstate_next;

    logic          start_reg, pause_reg, clear_reg, fetch_reg, bad_reg;
    logic [3:0]    rec_reg;
    logic [15:0]   last_cmd_reg;
    logic [AW-1:0] addr_reg, addr_next;
    logic [KW-1:0] k_reg, k_next;
    logic [15:0]   sum_reg, sum_next;
    logic [1:0]    wait_reg, wait_next;
    logic [CW-1:0] shadow_reg, shadow_next;
    logic [15:0]   word;

    // ---------------- read path ----------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rstate_reg <= R_IDLE;
        end else begin
            rstate_reg <= rstate_next;
        end
    end

    always_comb begin
        rstate_next = rstate_reg;
        usb_read_en = 1'b0;
        case (rstate_reg)
            R_IDLE: if (!usb_read_wait) rstate_next = R_POP;
            R_POP: begin
                usb_read_en = 1'b1;
                rstate_next = R_CAP;
            end
            R_CAP:   rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    // Decoded pulses are registered, so they appear in the cycle after R_CAP.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            start_reg    <= 1'b0;
            pause_reg    <= 1'b0;
            clear_reg    <= 1'b0;
            fetch_reg    <= 1'b0;
            bad_reg      <= 1'b0;
            rec_reg      <= 4'b0;
            last_cmd_reg <= 16'h0;
        end else begin
            start_reg <= 1'b0;
            pause_reg <= 1'b0;
            clear_reg <= 1'b0;
            fetch_reg <= 1'b0;
            if (rstate_reg == R_CAP) begin
                last_cmd_reg <= usb_read_data;
                bad_reg      <= 1'b0;
                if (usb_read_data == CMD_FETCH) begin
                    fetch_reg <= 1'b1;
                    rec_reg   <= 4'b0001;
                end else if (usb_read_data == CMD_START) begin
                    start_reg <= 1'b1;
                    rec_reg   <= 4'b0010;
                end else if (usb_read_data == CMD_PAUSE) begin
                    pause_reg <= 1'b1;
                    rec_reg   <= 4'b0100;
                end else if (usb_read_data == CMD_CLEAR) begin
                    clear_reg <= 1'b1;
                    rec_reg   <= 4'b1000;
                end else begin
                    bad_reg <= 1'b1;
                end
            end
        end
    end

    // ---------------- write path ----------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wstate_reg <= W_IDLE;
            addr_reg   <= '0;
            k_reg      <= '0;
            sum_reg    <= 16'h0;
            wait_reg   <= 2'b0;
            shadow_reg <= '0;
        end else begin
            wstate_reg <= wstate_next;
            addr_reg   <= addr_next;
            k_reg      <= k_next;
            sum_reg    <= sum_next;
            wait_reg   <= wait_next;
            shadow_reg <= shadow_next;
        end
    end

    assign word = shadow_reg[{k_reg, 4'b0000} +: 16];

    always_comb begin
        wstate_next    = wstate_reg;
        addr_next      = addr_reg;
        k_next         = k_reg;
        sum_next       = sum_reg;
        wait_next      = wait_reg;
        shadow_next    = shadow_reg;
        usb_write_en   = 1'b0;
        usb_write_data = (wstate_reg == W_SUM) ? sum_reg : word;
        // A fetch request always restarts from channel 0, even over a final write.
        if (fetch_reg) begin
            wstate_next = W_WAIT;
            addr_next   = '0;
            k_next      = '0;
            sum_next    = 16'h0;
            wait_next   = 2'b0;
        end else begin
            case (wstate_reg)
                W_IDLE: ;
                W_WAIT: begin
                    if (wait_reg == LAT) begin
                        shadow_next = channel_count;
                        wstate_next = W_WORD;
                    end else begin
                        wait_next = wait_reg + 2'd1;
                    end
                end
                W_WORD: begin
                    if (!usb_write_wait) begin
                        usb_write_en = 1'b1;
                        sum_next     = sum_reg + word;
                        wstate_next  = W_GAP;
                    end
                end
                W_GAP: begin
                    if (k_reg != K_LAST) begin
                        k_next      = k_reg + KW'(1);
                        wstate_next = W_WORD;
                    end else if (addr_reg != A_LAST) begin
                        addr_next   = addr_reg + AW'(1);
                        k_next      = '0;
                        wait_next   = 2'b0;
                        wstate_next = W_WAIT;
                    end else begin
                        wstate_next = (EN_SUM != 0) ? W_SUM : W_IDLE;
                    end
                end
                W_SUM: begin
                    if (!usb_write_wait) begin
                        usb_write_en = 1'b1;
                        wstate_next  = W_IDLE;
                    end
                end
                default: wstate_next = W_IDLE;
            endcase
        end
    end

    assign busy            = (wstate_reg != W_IDLE);
    assign channel_address = addr_reg;
    assign cmd_start       = start_reg;
    assign cmd_pause       = pause_reg;
    assign cmd_clear       = clear_reg;
    assign last_cmd        = last_cmd_reg;
    assign LEDG            = {3'b000, bad_reg, rec_reg, busy};
endmodule

// File: tb/tb_usb_hist_uploader.sv
// Scoreboard bench: stimulus pushes expected words/pulses, monitors pop and compare.
module tb_usb_hist_uploader;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rd_wait, rd_wait2, wr_wait;
    logic [15:0] rd_data;

    logic        rd_en1, wr_en1, start1, pause1, clear1, busy1;
    logic [15:0] wr_data1, last1;
    logic [1:0]  addr1;
    logic [31:0] count1;
    logic [8:0]  ledg1;

    logic        rd_en2, wr_en2, start2, pause2, clear2, busy2;
    logic [15:0] wr_data2, last2;
    logic [1:0]  addr2, p0, p1;
    logic [47:0] count2;
    logic [8:0]  ledg2;

    usb_hist_uploader #(.N_CH(4), .AW(2), .CW(32), .RD_LAT(1), .EN_SUM(1)) dut1 (
        .CLOCK_50(clk), .rst_n(rst_n), .usb_read_wait(rd_wait), .usb_read_en(rd_en1),
        .usb_read_data(rd_data), .usb_write_wait(wr_wait), .usb_write_en(wr_en1),
        .usb_write_data(wr_data1), .channel_address(addr1), .channel_count(count1),
        .cmd_start(start1), .cmd_pause(pause1), .cmd_clear(clear1), .busy(busy1),
        .last_cmd(last1), .LEDG(ledg1));

    usb_hist_uploader #(.N_CH(3), .AW(2), .CW(48), .RD_LAT(3), .EN_SUM(1)) dut2 (
        .CLOCK_50(clk), .rst_n(rst_n), .usb_read_wait(rd_wait2), .usb_read_en(rd_en2),
        .usb_read_data(rd_data), .usb_write_wait(1'b0), .usb_write_en(wr_en2),
        .usb_write_data(wr_data2), .channel_address(addr2), .channel_count(count2),
        .cmd_start(start2), .cmd_pause(pause2), .cmd_clear(clear2), .busy(busy2),
        .last_cmd(last2), .LEDG(ledg2));

    // Channel memories: 1-stage and 3-stage registered read pipelines.
    always @(posedge clk) count1 <= 32'h0001_0000 + 32'(addr1);
    always @(posedge clk) begin
        p0     <= addr2;
        p1     <= p0;
        count2 <= {16'h0002, 16'h0001, 14'd0, p1};
    end

    int total = 0;
    int bad   = 0;
    int strobes1 = 0;
    int strobes2 = 0;
    logic [15:0] exp1[$];
    logic [15:0] exp2[$];
    logic [2:0]  exp_p[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Write-port monitors
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en1) begin
                strobes1++;
                $display("dut1 strobe %0d data=%04h", strobes1, wr_data1);
                chk("dut1_back_to_back", 64'(prev), 64'd0);
                if (exp1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut1_unexpected_strobe: got %04h expected none", wr_data1);
                end else begin
                    chk("dut1_wdata", 64'(wr_data1), 64'(exp1.pop_front()));
                end
            end
            prev = rst_n && wr_en1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && wr_en2) begin
                strobes2++;
                $display("dut2 strobe %0d data=%04h addr=%0d", strobes2, wr_data2, addr2);
                if (exp2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut2_unexpected_strobe: got %04h expected none", wr_data2);
                end else begin
                    chk("dut2_wdata", 64'(wr_data2), 64'(exp2.pop_front()));
                end
            end
        end
    end

    // Command pulse monitor: {clear,pause,start}
    initial begin
        logic [2:0] prev = 3'b0;
        logic [2:0] code;
        forever begin
            @(negedge clk);
            code = {clear1, pause1, start1};
            if (rst_n && code != 3'b0) begin
                $display("dut1 pulse code=%b", code);
                chk("pulse_width", 64'(prev), 64'd0);
                if (exp_p.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: got %b expected none", code);
                end else begin
                    chk("pulse_kind", 64'(code), 64'(exp_p.pop_front()));
                end
            end
            prev = code;
        end
    end

    task automatic send(input int which, input logic [15:0] code);
        int n = 0;
        logic seen = 1'b0;
        rd_data = code;
        if (which == 1) rd_wait = 1'b0; else rd_wait2 = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (which == 1) ? rd_en1 : rd_en2;
        end
        chk("pop_seen", 64'(seen), 64'd1);
        rd_wait  = 1'b1;
        rd_wait2 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic push9();
        logic [15:0] w[9] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0002,
                              16'h0001, 16'h0003, 16'h0001, 16'h000A};
        for (int i = 0; i < 9; i++) exp1.push_back(w[i]);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobes1 < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("strobe_count_reached", 64'(strobes1 >= target), 64'd1);
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 1) ? exp1.size() : exp2.size()) > 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 64'((which == 1) ? exp1.size() : exp2.size()), 64'd0);
        @(negedge clk);
        #1;
        chk("busy_dropped", 64'((which == 1) ? busy1 : busy2), 64'd0);
    endtask

    initial begin
        int rd_hi = 0;
        int base;
        rst_n = 1'b0; rd_wait = 1'b1; rd_wait2 = 1'b1; wr_wait = 1'b0; rd_data = 16'h0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_outputs", 64'({rd_en1, wr_en1, busy1, start1, pause1, clear1}), 64'd0);
        chk("rst_wdata_addr", 64'({wr_data1, addr1}), 64'd0);
        chk("rst_last_ledg", 64'({last1, ledg1}), 64'd0);
        chk("rst_dut2", 64'({busy2, wr_en2, ledg2}), 64'd0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            rd_hi += int'(rd_en1);
        end
        chk("no_pop_while_wait", 64'(rd_hi), 64'd0);

        // Command decode
        exp_p.push_back(3'b001); send(1, 16'hFFEE);
        exp_p.push_back(3'b010); send(1, 16'hFFDD);
        exp_p.push_back(3'b100); send(1, 16'hFFCC);
        chk("ledg_clear", 64'(ledg1), 64'h010);
        send(1, 16'h1234);
        chk("pulses_drained", 64'(exp_p.size()), 64'd0);
        chk("last_cmd_1234", 64'(last1), 64'h1234);
        chk("ledg_unknown", 64'(ledg1), 64'h030);

        // Plain upload
        push9();
        send(1, 16'hFFFF);
        chk("ledg_fetch_busy", 64'(ledg1), 64'h003);
        drain(1);

        // Backpressure before word 3
        base = strobes1;
        push9();
        send(1, 16'hFFFF);
        wait_strobes(base + 2);
        wr_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (i >= 3) chk("held_data", 64'(wr_data1), 64'h0001);
        end
        chk("no_strobe_in_hold", 64'(strobes1 - base), 64'd2);
        wr_wait = 1'b0;
        drain(1);

        // Abort by a second FETCH after 4 words
        base = strobes1;
        push9();
        send(1, 16'hFFFF);
        wait_strobes(base + 4);
        wr_wait = 1'b1;
        send(1, 16'hFFFF);
        chk("abort_busy", 64'(busy1), 64'd1);
        chk("abort_addr0", 64'(addr1), 64'd0);
        exp1.delete();
        push9();
        chk("no_strobe_during_abort", 64'(strobes1 - base), 64'd4);
        wr_wait = 1'b0;
        drain(1);

        // Asynchronous reset mid-upload
        base = strobes1;
        push9();
        send(1, 16'hFFFF);
        wait_strobes(base + 5);
        rst_n = 1'b0;
        #1;
        chk("arst_busy_wen", 64'({busy1, wr_en1}), 64'd0);
        chk("arst_ledg_addr", 64'({ledg1, addr1}), 64'd0);
        exp1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = strobes1;
        repeat (30) @(negedge clk);
        #1;
        chk("no_strobe_after_reset", 64'(strobes1 - base), 64'd0);
        push9();
        send(1, 16'hFFFF);
        drain(1);

        // Wide counts with 3-cycle memory latency
        for (int a = 0; a < 3; a++) begin
            exp2.push_back(16'(a));
            exp2.push_back(16'h0001);
            exp2.push_back(16'h0002);
        end
        exp2.push_back(16'h000C);
        send(2, 16'hFFFF);
        drain(2);
        chk("dut2_total_words", 64'(strobes2), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
